data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and access sequencer for the 256-word `DataMemory`. It lets the CPU data path (port 0) and the program/data loader (port 1) share the single memory port through a req/ack handshake. Arbitration is round-robin by default, with exactly one access in flight at a time. It sits between the requesters and `DataMemory`, drives that block's `address`, `write_data`, `mem_write` and `mem_read` inputs, and registers its `read_data` output back to the winning requester.

## Interface
- `ADDR_W`, 32: requester and memory address width.
- `DATA_W`, 32: data width.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `m0_req`, `m1_req` in 1: access request; held high until the matching ack.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read; stable while req is high.
- `m0_addr`, `m1_addr` in ADDR_W: byte address; the memory uses bits [9:2].
- `m0_wdata`, `m1_wdata` in DATA_W: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata` out DATA_W: read result; valid while ack is high, held until the next read for that port.
- `mem_address` out ADDR_W: to `DataMemory.address`.
- `mem_write_data` out DATA_W: to `DataMemory.write_data`.
- `mem_write`, `mem_read` out 1: to `DataMemory` enables.
- `mem_read_data` in DATA_W: from `DataMemory.read_data`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE. Reset state is IDLE.
- **IDLE**
  - If any req is high, pick a winner.
  - Latch winner id, we, addr and wdata into the command registers.
  - Go to ACCESS.
- **ACCESS**
  - Drive `mem_address` and `mem_write_data` from the command registers.
  - `mem_write` = latched we; `mem_read` = !latched we.
  - On the closing edge, the write commits inside the memory, or `mem_read_data` is captured into the winner's rdata register.
  - Go to RESP.
- **RESP**
  - Winner's ack = 1.
  - Requests are not sampled in this state. Go to IDLE.
- Requester rules:
  - The requester drops req, or presents a new request, in the cycle after ack.
  - A req still high in the IDLE after RESP counts as a new access.
- Arbitration, round-robin:
  - `last_grant` register updates on every grant; reset value is 1, so the first tie goes to port 0.
  - On a tie, the port that did not win last time wins.
  - The losing req stays pending. It is served at the next IDLE.
- `mem_write` and `mem_read` are decoded from state and are never high outside ACCESS. `mem_address` and `mem_write_data` hold the last command value.
- Addresses pass through unchanged. Aliasing above 1 KiB is the memory's behaviour, not the arbiter's.

## Timing
- Output reset values:
  - `mem_write` = `mem_read` = 0.
  - `mem_address` = 0, `mem_write_data` = 0.
  - `m0_ack` = `m1_ack` = 0.
  - `m0_rdata` = `m1_rdata` = 0.
  - `busy` = 0.
- Latency: req sampled in IDLE at cycle 0 → ACCESS in cycle 1 → ack in cycle 2. Throughput is one access per 3 cycles.
- Read data is visible to the requester in the same cycle as ack (cycle 2).
- A write is visible to a read that enters ACCESS at cycle 4 or later.
- Both reqs rising in the same cycle: one is granted; the other is acked exactly 3 cycles after the first ack.
- A req dropped before ack (protocol violation): the latched access still completes and ack still fires.
- Reset mid-operation:
  - Forces IDLE immediately, asynchronously.
  - `mem_write` drops in the same cycle, so no write commits at the next edge.
  - The in-flight access is abandoned with no ack.
  - `last_grant` returns to 1.

## Configuration
- `DATA_ARB_FIXED_PRIO_EN` defined: port 0 always wins a tie and `last_grant` is not implemented. Port 1 is served only when `m0_req` is low in IDLE.
- Undefined (default): round-robin as described above.
- Latency, FSM and handshake are identical in both builds.

## Structure
- Shared package `data_arb_pkg` holds:
  - State encoding constants: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Port id constants: PORT0 = 1'b0, PORT1 = 1'b1.
  - The `ADDR_W`/`DATA_W` defaults.
- Sub-module `rr_arbiter_2` is natural. It is combinational: inputs are the two reqs and `last_grant`; output is the winner id. It contains the `DATA_ARB_FIXED_PRIO_EN` switch.
- The FSM, command registers and rdata registers stay in `data_mem_arbiter`.

## Test plan
- Reset then idle: all outputs 0 and `busy` = 0 for 10 cycles; the memory sees no write.
- Port 0 write: addr 0x08, wdata 0x0000_00AA, req at cycle 0. `mem_write` is high only in cycle 1, `m0_ack` is high in cycle 2, and memory word 2 = 0xAA.
- Port 1 read of the preloaded word at addr 0x04 (value 20): `m1_ack` is high in cycle 2 with `m1_rdata` = 20. `m1_rdata` holds 20 afterwards.
- Simultaneous requests, with both reqs held high over 4 grants:
  - Default build: grant order 0, 1, 0, 1.
  - With `DATA_ARB_FIXED_PRIO_EN`: port 0 is acked each round until `m0_req` drops.
- Back-to-back: port 0 writes 0x55 to 0x10, then port 1 reads 0x10. `m1_rdata` = 0x55, and `m1_ack` arrives exactly 3 cycles after `m0_ack`.
- Reset during ACCESS of a write to 0x0C: `mem_write` falls immediately, memory word 3 is unchanged, no ack is issued, and the state is IDLE.

Source files
------------

// File: rtl/data_arb_pkg.sv
// Shared definitions for the DataMemory arbiter: FSM state encoding, port ids, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_arb_pkg;

    // Default requester/memory widths
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester port ids
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester req/ack ports, the DataMemory port and the busy flag.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their one-cycle ack pulse.
interface data_mem_arbiter_if import data_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // Requester port 0 (CPU data path)
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    // Requester port 1 (program/data loader)
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    // DataMemory side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    logic              busy;

    // Arbiter view
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_read_data,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output mem_address, mem_write_data, mem_write, mem_read,
        output busy
    );

    // Requesters plus memory view
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_read_data,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  mem_address, mem_write_data, mem_write, mem_read,
        input  busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way request picker; round-robin on ties, or fixed port-0 priority with DATA_ARB_FIXED_PRIO_EN.
// Latency: combinational.
// Backpressure: none; the loser simply stays pending and is reconsidered next time.
module rr_arbiter_2 import data_arb_pkg::*; (
    input  logic req0,
    input  logic req1,
`ifndef DATA_ARB_FIXED_PRIO_EN
    input  logic last_grant,
`endif
    output logic grant
);

`ifdef DATA_ARB_FIXED_PRIO_EN
    // Port 0 wins whenever it asks; port 1 only when port 0 is quiet
    always_comb begin
        grant = (req0 || !req1) ? PORT0 : PORT1;
    end
`else
    // On a tie, hand the grant to whichever port did not win last time
    always_comb begin
        grant = PORT0;
        if (req0 && req1) begin
            grant = (last_grant == PORT0) ? PORT1 : PORT0;
        end else if (req1) begin
            grant = PORT1;
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single DataMemory port between two req/ack requesters, one access in flight (DATA_ARB_FIXED_PRIO_EN selects fixed priority).
// Latency: req sampled in IDLE -> memory access next cycle -> ack (and read data) the cycle after; 3 cycles per access.
// Backpressure: a losing or later request waits with req held high; requests are only sampled in IDLE.
module data_mem_arbiter import data_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave bus
);

    arb_state_t        state;

    // Command registers for the access in flight
    logic              cmd_port;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Per-port read result, held until that port's next read
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    logic              ack0;
    logic              ack1;
    logic              mem_we_q;
    logic              mem_re_q;

    logic              any_req;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifndef DATA_ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    rr_arbiter_2 u_rr_arbiter_2 (
        .req0       (bus.m0_req),
        .req1       (bus.m1_req),
`ifndef DATA_ARB_FIXED_PRIO_EN
        .last_grant (last_grant),
`endif
        .grant      (grant)
    );

    assign any_req   = bus.m0_req || bus.m1_req;
    assign sel_we    = (grant == PORT1) ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = (grant == PORT1) ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = (grant == PORT1) ? bus.m1_wdata : bus.m0_wdata;

    // Sequencer FSM: latch a winner in IDLE, drive the memory in ACCESS, pulse ack in RESP.
    // Memory enables are registered and set only for the ACCESS cycle, so an async reset
    // clears them at once and no write can commit on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_port   <= PORT0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
`ifndef DATA_ARB_FIXED_PRIO_EN
            last_grant <= PORT1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (any_req) begin
                        cmd_port   <= grant;
                        cmd_we     <= sel_we;
                        cmd_addr   <= sel_addr;
                        cmd_wdata  <= sel_wdata;
                        mem_we_q   <= sel_we;
                        mem_re_q   <= !sel_we;
`ifndef DATA_ARB_FIXED_PRIO_EN
                        last_grant <= grant;
`endif
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    if (!cmd_we) begin
                        if (cmd_port == PORT1) begin
                            rdata1 <= bus.mem_read_data;
                        end else begin
                            rdata0 <= bus.mem_read_data;
                        end
                    end
                    ack0  <= (cmd_port == PORT0);
                    ack1  <= (cmd_port == PORT1);
                    state <= RESP;
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_address    = cmd_addr;
    assign bus.mem_write_data = cmd_wdata;
    assign bus.mem_write      = mem_we_q;
    assign bus.mem_read       = mem_re_q;
    assign bus.m0_ack         = ack0;
    assign bus.m1_ack         = ack1;
    assign bus.m0_rdata       = rdata0;
    assign bus.m1_rdata       = rdata1;
    assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 256-word DataMemory model (async read, write on clock edge).
// Latency: checks ack two cycles after the sampling IDLE cycle and 3-cycle spacing between accesses.
// Backpressure: requesters hold req until ack, then drop or re-present it.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arbiter_if bus ();

    data_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // DataMemory model: word i preloaded to 0x1000+i, word 1 holds 20
    logic [31:0] dmem [256];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'h1000 + i;
            dmem[1] <= 32'd20;
        end else if (bus.mem_write) begin
            dmem[bus.mem_address[9:2]] <= bus.mem_write_data;
        end
    end

    assign bus.mem_read_data = dmem[bus.mem_address[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_order [5];
        bit   seen;
        int   t0;
        int   t1;

`ifdef DATA_ARB_FIXED_PRIO_EN
        exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0;
        exp_order[3] = 1'b0; exp_order[4] = 1'b1;
`else
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
        exp_order[3] = 1'b1; exp_order[4] = 1'b1;
`endif
        t0 = 0;
        t1 = 0;

        reset = 1'b1;
        mem_init = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        tick();
        tick();

        // Reset values
        chkb("rst_mem_write", bus.mem_write, 1'b0);
        chkb("rst_mem_read", bus.mem_read, 1'b0);
        chk ("rst_mem_address", bus.mem_address, 32'h0);
        chk ("rst_mem_write_data", bus.mem_write_data, 32'h0);
        chkb("rst_m0_ack", bus.m0_ack, 1'b0);
        chkb("rst_m1_ack", bus.m1_ack, 1'b0);
        chk ("rst_m0_rdata", bus.m0_rdata, 32'h0);
        chk ("rst_m1_rdata", bus.m1_rdata, 32'h0);
        chkb("rst_busy", bus.busy, 1'b0);

        reset = 1'b0;
        mem_init = 1'b0;

        // Idle for 10 cycles with no requests
        for (int i = 0; i < 10; i++) begin
            tick();
            chkb("idle_busy", bus.busy, 1'b0);
            chkb("idle_mem_write", bus.mem_write, 1'b0);
            chkb("idle_acks", bus.m0_ack | bus.m1_ack, 1'b0);
        end
        chk("idle_word2", dmem[2], 32'h1002);

        // Port 0 write 0xAA to 0x08
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h08; bus.m0_wdata = 32'hAA;
        chkb("w0_c0_mem_write", bus.mem_write, 1'b0);
        tick();
        chkb("w0_c1_mem_write", bus.mem_write, 1'b1);
        chkb("w0_c1_mem_read", bus.mem_read, 1'b0);
        chk ("w0_c1_addr", bus.mem_address, 32'h08);
        chk ("w0_c1_wdata", bus.mem_write_data, 32'hAA);
        chkb("w0_c1_busy", bus.busy, 1'b1);
        chkb("w0_c1_ack", bus.m0_ack, 1'b0);
        tick();
        chkb("w0_c2_ack", bus.m0_ack, 1'b1);
        chkb("w0_c2_m1_ack", bus.m1_ack, 1'b0);
        chkb("w0_c2_mem_write", bus.mem_write, 1'b0);
        bus.m0_req = 1'b0;
        tick();
        chkb("w0_c3_ack", bus.m0_ack, 1'b0);
        chkb("w0_c3_busy", bus.busy, 1'b0);
        chk ("w0_word2", dmem[2], 32'hAA);
        chk ("w0_addr_hold", bus.mem_address, 32'h08);

        // Port 1 read of preloaded word at 0x04
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h04;
        tick();
        chkb("r1_c1_mem_read", bus.mem_read, 1'b1);
        chkb("r1_c1_mem_write", bus.mem_write, 1'b0);
        chk ("r1_c1_addr", bus.mem_address, 32'h04);
        tick();
        chkb("r1_c2_ack", bus.m1_ack, 1'b1);
        chk ("r1_c2_rdata", bus.m1_rdata, 32'd20);
        chkb("r1_c2_m0_ack", bus.m0_ack, 1'b0);
        bus.m1_req = 1'b0;
        tick();
        chkb("r1_c3_ack", bus.m1_ack, 1'b0);
        chk ("r1_c3_rdata_hold", bus.m1_rdata, 32'd20);
        tick();
        chk ("r1_c4_rdata_hold", bus.m1_rdata, 32'd20);

        // Both requesters reading, held across grants; port 0 drops after the 4th grant
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h08;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h04;
        for (int k = 0; k < 5; k++) begin
            tick();
            chkb("tie_c1_busy", bus.busy, 1'b1);
            tick();
            chkb("tie_m0_ack", bus.m0_ack, !exp_order[k]);
            chkb("tie_m1_ack", bus.m1_ack, exp_order[k]);
            if (exp_order[k]) chk("tie_m1_rdata", bus.m1_rdata, 32'd20);
            else              chk("tie_m0_rdata", bus.m0_rdata, 32'hAA);
            if (k == 3) bus.m0_req = 1'b0;
            if (k == 4) bus.m1_req = 1'b0;
            tick();
        end
        chkb("tie_done_busy", bus.busy, 1'b0);

        // Back-to-back: port 0 writes 0x55 to 0x10, port 1 then reads 0x10
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h10; bus.m0_wdata = 32'h55;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h10;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.m0_ack) begin seen = 1'b1; t0 = cyc; end
        end
        chkb("b2b_m0_ack_seen", seen, 1'b1);
        bus.m0_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.m1_ack) begin seen = 1'b1; t1 = cyc; end
        end
        chkb("b2b_m1_ack_seen", seen, 1'b1);
        chk ("b2b_spacing", 32'(t1 - t0), 32'd3);
        chk ("b2b_m1_rdata", bus.m1_rdata, 32'h55);
        bus.m1_req = 1'b0;
        tick();

        // Port 1 write with req dropped before ack: access still completes
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h14; bus.m1_wdata = 32'h77;
        tick();
        bus.m1_req = 1'b0;
        chkb("drop_c1_mem_write", bus.mem_write, 1'b1);
        tick();
        chkb("drop_c2_ack", bus.m1_ack, 1'b1);
        tick();
        chk ("drop_word5", dmem[5], 32'h77);

        // Reset during ACCESS of a write to 0x0C
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h0C; bus.m0_wdata = 32'hDEAD;
        tick();
        chkb("rstw_c1_mem_write", bus.mem_write, 1'b1);
        #1;
        reset = 1'b1;
        bus.m0_req = 1'b0;
        #1;
        chkb("rstw_mem_write_drop", bus.mem_write, 1'b0);
        chkb("rstw_busy", bus.busy, 1'b0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.m0_ack || bus.m1_ack) seen = 1'b1;
            tick();
        end
        chkb("rstw_no_ack", seen, 1'b0);
        chk ("rstw_word3", dmem[3], 32'h1003);
        chkb("rstw_idle", bus.busy, 1'b0);

        // After reset the first tie goes to port 0 again
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h04;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h04;
        tick();
        tick();
        chkb("post_rst_m0_ack", bus.m0_ack, 1'b1);
        chkb("post_rst_m1_ack", bus.m1_ack, 1'b0);
        chk ("post_rst_m0_rdata", bus.m0_rdata, 32'd20);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
